// File: rtl/rr_arb3_sel.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb3_sel
// Purpose  : Three-requester round-robin arbiter that produces the registered,
//            break-before-make one-hot select legs (A1/B1/C1) of an AOI222
//            used as a 3:1 inverting mux. Optional hold timeout.
// Revision : 1.0  initial release
// ============================================================================
module rr_arb3_sel #(
  parameter int MAX_HOLD = 8,   // max consecutive grant cycles, 0 = no limit
  parameter int CW       = 4    // hold counter width, 2**CW > MAX_HOLD
) (
  input  logic       CK,
  input  logic       RN,
  input  logic [2:0] REQ,
  input  logic       DONE,
  output logic [2:0] GNT,
  output logic [1:0] GNT_ID,
  output logic       BUSY,
  output logic       TIMEOUT
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  localparam logic [CW-1:0] c_hold_max  = {CW{1'b1}};
  localparam logic [CW-1:0] c_hold_one  = CW'(1);
  localparam logic [CW-1:0] c_hold_last = (MAX_HOLD == 0) ? '0 : CW'(MAX_HOLD - 1);
  localparam logic [1:0]    c_id_none   = 2'd3;

  state_t        r_state;
  logic [2:0]    r_gnt;
  logic [1:0]    r_gnt_id;
  logic          r_busy;
  logic          r_timeout;
  logic [1:0]    r_last;
  logic [CW-1:0] r_hold;

  state_t        w_state_nxt;
  logic [2:0]    w_gnt_nxt;
  logic [1:0]    w_id_nxt;
  logic          w_to_nxt;
  logic [1:0]    w_last_nxt;
  logic [CW-1:0] w_hold_nxt;

  logic [1:0]    w_win_id;
  logic          w_win_vld;
  logic          w_to_hit;

  // Round-robin winner: search LAST+1, LAST+2, LAST (mod 3)
  always_comb begin
    w_win_id  = 2'd0;
    w_win_vld = |REQ;
    case (r_last)
      2'd0: begin
        if (REQ[1])      w_win_id = 2'd1;
        else if (REQ[2]) w_win_id = 2'd2;
        else             w_win_id = 2'd0;
      end
      2'd1: begin
        if (REQ[2])      w_win_id = 2'd2;
        else if (REQ[0]) w_win_id = 2'd0;
        else             w_win_id = 2'd1;
      end
      default: begin
        if (REQ[0])      w_win_id = 2'd0;
        else if (REQ[1]) w_win_id = 2'd1;
        else             w_win_id = 2'd2;
      end
    endcase
  end

  // Timeout fires on the edge where the hold count reaches MAX_HOLD-1
  assign w_to_hit = (MAX_HOLD != 0) && (r_hold == c_hold_last);

  // Next-state and next-output logic; every release passes through IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_id_nxt    = r_gnt_id;
    w_to_nxt    = 1'b0;
    w_last_nxt  = r_last;
    w_hold_nxt  = r_hold;
    case (r_state)
      S_IDLE: begin
        if (w_win_vld) begin
          w_state_nxt = S_GRANT;
          w_gnt_nxt   = 3'b001 << w_win_id;
          w_id_nxt    = w_win_id;
          w_last_nxt  = w_win_id;
          w_hold_nxt  = '0;
        end
      end
      S_GRANT: begin
        if (DONE || !REQ[r_last]) begin
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = 3'b000;
          w_id_nxt    = c_id_none;
        end else if (w_to_hit) begin
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = 3'b000;
          w_id_nxt    = c_id_none;
          w_to_nxt    = 1'b1;
        end else if (r_hold != c_hold_max) begin
          w_hold_nxt  = r_hold + c_hold_one;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = 3'b000;
        w_id_nxt    = c_id_none;
      end
    endcase
  end

  // State and output registers; reset puts requester 0 first in line
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_state   <= S_IDLE;
      r_gnt     <= 3'b000;
      r_gnt_id  <= c_id_none;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_last    <= 2'd2;
      r_hold    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_gnt_id  <= w_id_nxt;
      r_busy    <= |w_gnt_nxt;
      r_timeout <= w_to_nxt;
      r_last    <= w_last_nxt;
      r_hold    <= w_hold_nxt;
    end
  end

  assign GNT     = r_gnt;
  assign GNT_ID  = r_gnt_id;
  assign BUSY    = r_busy;
  assign TIMEOUT = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb3_sel.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arb3_sel
// Purpose  : Self-checking bench for rr_arb3_sel (MAX_HOLD=8 and MAX_HOLD=0
//            instances) against a behavioural arbiter model, including an
//            AOI222 inverting-mux model on the select legs.
// Revision : 1.0  initial release
// ============================================================================
module tb_rr_arb3_sel;

  localparam int c_hmax = 15;

  typedef struct {
    int g;      // granted requester, -1 when nothing granted
    int last;
    int hold;
    bit to;
  } mdl_t;

  logic       CK = 1'b0;
  logic       RN = 1'b0;
  logic [2:0] REQ = 3'b000;
  logic       DONE = 1'b0;

  logic [2:0] gnt8, gnt0;
  logic [1:0] id8, id0;
  logic       busy8, busy0, to8, to0;
  logic [2:0] data = 3'b101;   // A2=1, B2=0, C2=1
  logic       zn8, zn0;
  logic [2:0] prev8 = 3'b000;
  logic [2:0] prev0 = 3'b000;

  int n_checks = 0;
  int n_fail   = 0;

  mdl_t m8, m0;

  rr_arb3_sel #(.MAX_HOLD(8), .CW(4)) dut8 (
    .CK(CK), .RN(RN), .REQ(REQ), .DONE(DONE),
    .GNT(gnt8), .GNT_ID(id8), .BUSY(busy8), .TIMEOUT(to8)
  );

  rr_arb3_sel #(.MAX_HOLD(0), .CW(4)) dut0 (
    .CK(CK), .RN(RN), .REQ(REQ), .DONE(DONE),
    .GNT(gnt0), .GNT_ID(id0), .BUSY(busy0), .TIMEOUT(to0)
  );

  // AOI222_X1 behaviour: ZN = ~(A1&A2 | B1&B2 | C1&C2)
  assign zn8 = ~((gnt8[0] & data[0]) | (gnt8[1] & data[1]) | (gnt8[2] & data[2]));
  assign zn0 = ~((gnt0[0] & data[0]) | (gnt0[1] & data[1]) | (gnt0[2] & data[2]));

  always #5 CK = ~CK;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic mdl_t mdl_reset();
    mdl_t s;
    s.g = -1; s.last = 2; s.hold = 0; s.to = 1'b0;
    return s;
  endfunction

  // One rising edge of the arbiter, written from the behavioural rules
  function automatic mdl_t mdl_step(mdl_t s, int mh, logic [2:0] req, logic done);
    mdl_t n = s;
    n.to = 1'b0;
    if (s.g < 0) begin
      for (int k = 1; k <= 3; k++) begin
        int c;
        c = (s.last + k) % 3;
        if (req[c] && n.g < 0) begin
          n.g = c; n.last = c; n.hold = 0;
        end
      end
    end else if (done || !req[s.g]) begin
      n.g = -1;
    end else if (mh != 0 && s.hold == mh - 1) begin
      n.g = -1; n.to = 1'b1;
    end else if (s.hold < c_hmax) begin
      n.hold = s.hold + 1;
    end
    return n;
  endfunction

  task automatic check_dut(input string nm, input mdl_t m, input logic [2:0] gnt,
                           input logic [1:0] id, input logic busy, input logic to,
                           input logic zn, input logic [2:0] prev);
    logic [2:0] eg;
    logic [1:0] ei;
    logic       ez;
    eg = (m.g < 0) ? 3'b000 : 3'(1 << m.g);
    ei = (m.g < 0) ? 2'd3 : 2'(m.g);
    ez = (m.g < 0) ? 1'b1 : ~data[m.g];
    chk_eq({nm, "_gnt"},    32'(gnt),  32'(eg));
    chk_eq({nm, "_id"},     32'(id),   32'(ei));
    chk_eq({nm, "_busy"},   32'(busy), 32'(m.g >= 0));
    chk_eq({nm, "_to"},     32'(to),   32'(m.to));
    chk_eq({nm, "_zn"},     32'(zn),   32'(ez));
    chk_eq({nm, "_onehot"}, 32'($onehot0(gnt)), 32'd1);
    chk_eq({nm, "_bbm"},    32'(prev == 3'b000 || gnt == 3'b000 || gnt == prev), 32'd1);
  endtask

  task automatic check_all();
    check_dut("d8", m8, gnt8, id8, busy8, to8, zn8, prev8);
    check_dut("d0", m0, gnt0, id0, busy0, to0, zn0, prev0);
    prev8 = gnt8;
    prev0 = gnt0;
  endtask

  // Drive inputs, take one edge, advance the models, check after the edge
  task automatic cycle(input logic [2:0] r, input logic d);
    REQ  = r;
    DONE = d;
    @(posedge CK);
    if (RN) begin
      m8 = mdl_step(m8, 8, r, d);
      m0 = mdl_step(m0, 0, r, d);
    end
    #1;
    check_all();
  endtask

  initial begin
    logic [2:0] rot_g  [7] = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
    logic [1:0] rot_id [7] = '{2'd0, 2'd3, 2'd1, 2'd3, 2'd2, 2'd3, 2'd0};
    int run;
    int n_to;
    bit done_at_7;

    m8 = mdl_reset();
    m0 = mdl_reset();

    // Reset state
    repeat (2) @(posedge CK);
    #1;
    check_all();
    @(negedge CK);
    RN = 1'b1;

    // Grant requester 1, then asynchronous reset mid-grant
    cycle(3'b010, 1'b0);
    chk_eq("pre_rst_gnt", 32'(gnt8), 32'h2);
    #2;
    RN = 1'b0;
    #1;
    m8 = mdl_reset();
    m0 = mdl_reset();
    chk_eq("async_rst_gnt",  32'(gnt8),  32'h0);
    chk_eq("async_rst_id",   32'(id8),   32'h3);
    chk_eq("async_rst_busy", 32'(busy8), 32'h0);
    check_all();
    @(posedge CK);
    #1;
    check_all();
    @(negedge CK);
    RN = 1'b1;

    // Rotation with REQ=111 and DONE one cycle after each grant
    for (int i = 0; i < 7; i++) begin
      cycle(3'b111, (m8.g >= 0));
      chk_eq("rot_gnt", 32'(gnt8), 32'(rot_g[i]));
      chk_eq("rot_id",  32'(id8),  32'(rot_id[i]));
    end

    // Timeout: REQ=010 held, no DONE
    run = 0;
    n_to = 0;
    for (int i = 0; i < 25; i++) begin
      cycle(3'b010, 1'b0);
      if (gnt8 == 3'b010) run++;
      else begin
        if (to8) begin
          n_to++;
          chk_eq("to_run_len", 32'(run), 32'd8);
        end
        run = 0;
      end
    end
    chk_eq("to_count", 32'(n_to), 32'd2);

    // DONE on the edge where the timeout would fire
    for (int i = 0; i < 20; i++) begin
      done_at_7 = (m8.g >= 0) && (m8.hold == 7);
      cycle(3'b010, done_at_7);
      if (done_at_7) chk_eq("done_wins_to", 32'(to8), 32'd0);
    end

    // Withdrawal then skip to requester 2
    cycle(3'b000, 1'b0);
    cycle(3'b000, 1'b0);
    cycle(3'b010, 1'b0);
    chk_eq("wd_grant1", 32'(gnt8), 32'h2);
    cycle(3'b101, 1'b0);
    chk_eq("wd_release", 32'(gnt8), 32'h0);
    cycle(3'b101, 1'b0);
    chk_eq("wd_next_r2", 32'(gnt8), 32'h4);

    // MAX_HOLD=0: grant held indefinitely, hold counter saturates
    cycle(3'b000, 1'b0);
    cycle(3'b000, 1'b0);
    for (int i = 0; i < 100; i++) begin
      cycle(3'b001, 1'b0);
      chk_eq("nohold_gnt", 32'(gnt0), 32'h1);
      chk_eq("nohold_to",  32'(to0),  32'h0);
    end
    chk_eq("hold_sat", 32'(dut0.r_hold), 32'(m0.hold));
    chk_eq("hold_sat15", 32'(m0.hold), 32'd15);

    // Random REQ / DONE
    for (int i = 0; i < 500; i++) begin
      cycle(3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
